// File: rtl/reg_file_2r1w.sv
// 32-entry architectural register file with two combinational read ports, one clocked write port,
// a hardwired zero register and same-cycle write-to-read bypass.
module reg_file_2r1w #(
   parameter int WIDTH    = 64,
   parameter int ZERO_REG = 31
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [4:0]       read_reg1,
   input  logic [4:0]       read_reg2,
   input  logic [4:0]       write_reg,
   input  logic [WIDTH-1:0] write_data,
   input  logic             reg_write,
   output logic [WIDTH-1:0] read_data1,
   output logic [WIDTH-1:0] read_data2
);

   localparam logic [4:0] ZERO_IDX = 5'(ZERO_REG);

   logic [WIDTH-1:0] regs_q [32];
   logic [WIDTH-1:0] regs_d [32];
   logic             wr_en;

   assign wr_en = reg_write && (write_reg != ZERO_IDX);

   // The zero entry is held at constant 0, so synthesis removes its flops.
   always_comb begin
      regs_d = regs_q;
      if (wr_en) begin
         regs_d[write_reg] = write_data;
      end
      regs_d[ZERO_REG] = '0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 32; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   function automatic logic [WIDTH-1:0] read_port(input logic [4:0] addr);
      logic [WIDTH-1:0] val;
      val = '0;
      if (!reset_n || addr == ZERO_IDX) begin
         val = '0;
      end else if (reg_write && write_reg == addr) begin
         val = write_data;
      end else begin
         val = regs_q[addr];
      end
      return val;
   endfunction

   always_comb begin
      read_data1 = read_port(read_reg1);
      read_data2 = read_port(read_reg2);
   end

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Directed bench for reg_file_2r1w: reset, write/read, bypass, zero register, write enable, sweep.
module tb_reg_file_2r1w;

   localparam int WIDTH = 64;

   logic             clk;
   logic             reset_n;
   logic [4:0]       read_reg1;
   logic [4:0]       read_reg2;
   logic [4:0]       write_reg;
   logic [WIDTH-1:0] write_data;
   logic             reg_write;
   logic [WIDTH-1:0] read_data1;
   logic [WIDTH-1:0] read_data2;

   int total = 0;
   int bad   = 0;

   reg_file_2r1w #(.WIDTH(WIDTH), .ZERO_REG(31)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .read_reg1  (read_reg1),
      .read_reg2  (read_reg2),
      .write_reg  (write_reg),
      .write_data (write_data),
      .reg_write  (reg_write),
      .read_data1 (read_data1),
      .read_data2 (read_data2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive a write at the current negedge, let one rising edge capture it, return at the next negedge.
   task automatic do_write(input logic [4:0] addr, input logic [WIDTH-1:0] data);
      reg_write  = 1'b1;
      write_reg  = addr;
      write_data = data;
      @(posedge clk);
      @(negedge clk);
      reg_write  = 1'b0;
   endtask

   initial begin
      reset_n    = 1'b0;
      read_reg1  = 5'd0;
      read_reg2  = 5'd0;
      write_reg  = 5'd0;
      write_data = '0;
      reg_write  = 1'b0;

      @(negedge clk);
      #1 check("reset_rd1", read_data1, 64'h0);
      check("reset_rd2", read_data2, 64'h0);
      @(negedge clk);
      reset_n = 1'b1;

      // Reset clears a preloaded entry asynchronously
      do_write(5'd5, 64'h1234);
      read_reg1 = 5'd5;
      #1 check("preload_x5", read_data1, 64'h1234);
      #1 reset_n = 1'b0;
      #1 check("async_reset_x5", read_data1, 64'h0);
      @(negedge clk);
      reset_n = 1'b1;
      #1 check("after_reset_x5", read_data1, 64'h0);

      // Basic write and read on both ports
      @(negedge clk);
      do_write(5'd3, 64'hDEAD_BEEF_0000_0001);
      read_reg1 = 5'd3;
      read_reg2 = 5'd3;
      #1 check("x3_rd1", read_data1, 64'hDEAD_BEEF_0000_0001);
      check("x3_rd2", read_data2, 64'hDEAD_BEEF_0000_0001);
      read_reg1 = 5'd4;
      #1 check("x4_zero", read_data1, 64'h0);

      // Bypass before the edge, storage after it
      @(negedge clk);
      reg_write  = 1'b1;
      write_reg  = 5'd7;
      write_data = 64'hAA55;
      read_reg2  = 5'd7;
      #1 check("bypass_pre", read_data2, 64'hAA55);
      @(posedge clk);
      @(negedge clk);
      reg_write  = 1'b0;
      write_data = 64'h0;
      #1 check("bypass_post", read_data2, 64'hAA55);

      // Zero register ignores writes and never bypasses
      @(negedge clk);
      reg_write  = 1'b1;
      write_reg  = 5'd31;
      write_data = 64'hFFFF_FFFF_FFFF_FFFF;
      read_reg1  = 5'd31;
      read_reg2  = 5'd31;
      #1 check("xzr_during_rd1", read_data1, 64'h0);
      check("xzr_during_rd2", read_data2, 64'h0);
      @(posedge clk);
      @(negedge clk);
      reg_write = 1'b0;
      #1 check("xzr_after", read_data1, 64'h0);

      // Write enable low: no write, no bypass
      @(negedge clk);
      do_write(5'd9, 64'h11);
      write_reg  = 5'd9;
      write_data = 64'h77;
      read_reg1  = 5'd9;
      #1 check("we_low_pre", read_data1, 64'h11);
      @(posedge clk);
      @(negedge clk);
      #1 check("we_low_post", read_data1, 64'h11);

      // Both ports bypass the same register, then read it from storage
      @(negedge clk);
      reg_write  = 1'b1;
      write_reg  = 5'd12;
      write_data = 64'h0123_4567_89AB_CDEF;
      read_reg1  = 5'd12;
      read_reg2  = 5'd12;
      #1 check("dual_bypass_rd1", read_data1, 64'h0123_4567_89AB_CDEF);
      check("dual_bypass_rd2", read_data2, 64'h0123_4567_89AB_CDEF);
      @(posedge clk);
      @(negedge clk);
      reg_write  = 1'b0;
      write_data = 64'h0;
      #1 check("dual_post_rd1", read_data1, 64'h0123_4567_89AB_CDEF);
      check("dual_post_rd2", read_data2, 64'h0123_4567_89AB_CDEF);

      // Reset falls while a write is pending: the write is lost
      @(negedge clk);
      reg_write  = 1'b1;
      write_reg  = 5'd10;
      write_data = 64'h55;
      read_reg1  = 5'd10;
      #1 check("pend_bypass", read_data1, 64'h55);
      #1 reset_n = 1'b0;
      #1 check("pend_reset_rd", read_data1, 64'h0);
      @(posedge clk);
      @(negedge clk);
      reg_write = 1'b0;
      reset_n   = 1'b1;
      #1 check("pend_lost_x10", read_data1, 64'h0);
      read_reg1 = 5'd3;
      #1 check("x3_cleared", read_data1, 64'h0);

      // Full sweep: entry i holds i*0x0101
      @(negedge clk);
      for (int i = 0; i < 31; i++) begin
         do_write(5'(i), 64'(i * 32'h0101));
      end
      write_data = 64'h0;
      for (int i = 0; i < 31; i++) begin
         read_reg1 = 5'(i);
         read_reg2 = 5'(30 - i);
         #1 check($sformatf("sweep_rd1_%0d", i), read_data1, 64'(i * 32'h0101));
         check($sformatf("sweep_rd2_%0d", 30 - i), read_data2, 64'((30 - i) * 32'h0101));
      end
      read_reg1 = 5'd31;
      #1 check("sweep_xzr", read_data1, 64'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
